// File: rtl/dm_page_sched.sv
// dm_page_sched: rotates two data pages on the 8-digit display, overridden by a blinking timed message.
module dm_page_sched #(
  parameter int PAGE_TICKS     = 100000000,
  parameter int BLINK_TICKS    = 25000000,
  parameter int MSG_HOLD_TICKS = 200000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_1,
  input  logic [15:0] data_2,
  input  logic [1:0]  gen_mod,
  input  logic [2:0]  prog,
  input  logic        freeze,
  input  logic        msg_req,
  input  logic [15:0] msg_code,
  output logic        msg_busy,
  output logic [1:0]  page,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);
  localparam int PW = $clog2(PAGE_TICKS);
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = $clog2(MSG_HOLD_TICKS);
  typedef enum logic [1:0] {PAGE0 = 2'd0, PAGE1 = 2'd1, MSG = 2'd2} state_t;
  state_t         r_state, w_state;
  logic           r_last, w_last;
  logic [PW-1:0]  r_page_cnt, w_page_cnt;
  logic [BW-1:0]  r_blink_cnt, w_blink_cnt;
  logic [HW-1:0]  r_hold_cnt, w_hold_cnt;
  logic           r_blink_on, w_blink_on;
  logic [15:0]    r_msg_lat, w_msg_lat;
  logic [5:0]     r_d [8];
  logic [5:0]     w_d [8];
  logic [15:0]    w_src;
  logic           w_page_tc, w_blink_tc, w_hold_tc;
  assign w_page_tc  = r_page_cnt == PW'(PAGE_TICKS - 1);
  assign w_blink_tc = r_blink_cnt == BW'(BLINK_TICKS - 1);
  assign w_hold_tc  = r_hold_cnt == HW'(MSG_HOLD_TICKS - 1);
  assign w_src      = r_state == PAGE1 ? data_1 : data_2;
  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_page_cnt  = r_page_cnt;
    w_blink_cnt = r_blink_cnt;
    w_hold_cnt  = r_hold_cnt;
    w_blink_on  = r_blink_on;
    w_msg_lat   = r_msg_lat;
    // a request (entry or retrigger) beats both hold expiry and the page terminal count
    if (msg_req) begin
      w_state     = MSG;
      w_msg_lat   = msg_code;
      w_hold_cnt  = '0;
      w_blink_cnt = '0;
      w_blink_on  = 1'b1;
      w_last      = r_state == MSG ? r_last : r_state == PAGE1;
    end else if (r_state == MSG) begin
      w_hold_cnt  = w_hold_tc ? '0 : r_hold_cnt + 1'b1;
      w_blink_cnt = w_blink_tc ? '0 : r_blink_cnt + 1'b1;
      w_blink_on  = w_hold_tc | (w_blink_tc ? ~r_blink_on : r_blink_on);
      w_state     = w_hold_tc ? (r_last ? PAGE1 : PAGE0) : MSG;
    end else if (!freeze) begin
      w_page_cnt = w_page_tc ? '0 : r_page_cnt + 1'b1;
      w_state    = w_page_tc ? (r_state == PAGE0 ? PAGE1 : PAGE0) : r_state;
    end
  end
  always_comb begin
    for (int k = 0; k < 8; k++) w_d[k] = '0;
    if (r_state == MSG) begin
      for (int k = 0; k < 4; k++) w_d[k] = {r_blink_on, r_msg_lat[4*k +: 4], 1'b0};
    end else begin
      for (int k = 0; k < 4; k++) w_d[k] = {1'b1, w_src[4*k +: 4], 1'b0};
      w_d[5] = r_state == PAGE0 ? {1'b1, 2'b0, gen_mod, 1'b0} : 6'b0;
      w_d[7] = r_state == PAGE0 ? {1'b1, 1'b0, prog, freeze} : {1'b1, 4'h1, freeze};
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= PAGE0;
      r_last      <= 1'b0;
      r_page_cnt  <= '0;
      r_blink_cnt <= '0;
      r_hold_cnt  <= '0;
      r_blink_on  <= 1'b1;
      r_msg_lat   <= '0;
      r_d         <= '{default: '0};
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_page_cnt  <= w_page_cnt;
      r_blink_cnt <= w_blink_cnt;
      r_hold_cnt  <= w_hold_cnt;
      r_blink_on  <= w_blink_on;
      r_msg_lat   <= w_msg_lat;
      r_d         <= w_d;
    end
  end
  assign msg_busy = r_state == MSG;
  assign page     = r_state;
  assign d1 = r_d[0];
  assign d2 = r_d[1];
  assign d3 = r_d[2];
  assign d4 = r_d[3];
  assign d5 = r_d[4];
  assign d6 = r_d[5];
  assign d7 = r_d[6];
  assign d8 = r_d[7];
endmodule

// File: tb/tb_dm_page_sched.sv
// tb_dm_page_sched: directed and random checks of dm_page_sched against a cycle-count reference model.
module tb_dm_page_sched;
  localparam int PT = 8;
  localparam int BT = 2;
  localparam int HT = 12;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_1 = '0, data_2 = '0, msg_code = '0;
  logic [1:0]  gen_mod = '0;
  logic [2:0]  prog = '0;
  logic        freeze = 1'b0, msg_req = 1'b0;
  logic        msg_busy;
  logic [1:0]  page;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  int checks = 0;
  int errors = 0;
  int m_mode, m_elapsed, m_last, m_age;
  logic [15:0] m_msg;
  logic [5:0]  exp_d [8];

  dm_page_sched #(.PAGE_TICKS(PT), .BLINK_TICKS(BT), .MSG_HOLD_TICKS(HT)) dut (
    .clock(clock), .reset(reset), .data_1(data_1), .data_2(data_2),
    .gen_mod(gen_mod), .prog(prog), .freeze(freeze), .msg_req(msg_req),
    .msg_code(msg_code), .msg_busy(msg_busy), .page(page),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] dig(input int k);
    case (k)
      0: return d1;
      1: return d2;
      2: return d3;
      3: return d4;
      4: return d5;
      5: return d6;
      6: return d7;
      default: return d8;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_last = 0; m_age = 0; m_msg = '0;
  endtask

  // frame from the pre-edge situation, then advance by one clock
  task automatic model_step();
    logic [15:0] src;
    logic on;
    for (int k = 0; k < 8; k++) exp_d[k] = '0;
    if (m_mode == 2) begin
      on = ((m_age / BT) % 2) == 0;
      for (int k = 0; k < 4; k++) exp_d[k] = {on, m_msg[4*k +: 4], 1'b0};
    end else begin
      src = (m_mode == 1) ? data_1 : data_2;
      for (int k = 0; k < 4; k++) exp_d[k] = {1'b1, src[4*k +: 4], 1'b0};
      if (m_mode == 0) begin
        exp_d[5] = {1'b1, 2'b00, gen_mod, 1'b0};
        exp_d[7] = {1'b1, 1'b0, prog, freeze};
      end else exp_d[7] = {1'b1, 4'h1, freeze};
    end
    if (msg_req) begin
      if (m_mode != 2) m_last = m_mode;
      m_mode = 2; m_age = 0; m_msg = msg_code;
    end else if (m_mode == 2) begin
      m_age++;
      if (m_age == HT) m_mode = m_last;
    end else if (!freeze) begin
      m_elapsed++;
      if (m_elapsed == PT) begin
        m_elapsed = 0;
        m_mode = 1 - m_mode;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 8; k++) chk($sformatf("d%0d", k + 1), 16'(dig(k)), 16'(exp_d[k]));
    chk("page", 16'(page), 16'(m_mode));
    chk("msg_busy", 16'(msg_busy), 16'(m_mode == 2));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1 check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    data_2 = 16'hBEEF; gen_mod = 2'd2; prog = 3'd5;
    for (int k = 0; k < 8; k++) chk($sformatf("reset_d%0d", k + 1), 16'(dig(k)), 16'h0);
    chk("reset_page", 16'(page), 16'h0);
    chk("reset_busy", 16'(msg_busy), 16'h0);
    @(negedge clock) reset = 1'b1;
    cycle();
    chk("first_d1", 16'(d1), 16'h3E);
    chk("first_d4", 16'(d4), 16'h36);
    chk("first_d6", 16'(d6), 16'h24);
    chk("first_d8", 16'(d8), 16'h2A);
    data_1 = 16'h1234;
    run(8);
    chk("p1_d1", 16'(d1), 16'h28);
    chk("p1_d8", 16'(d8), 16'h22);
    chk("p1_page", 16'(page), 16'h1);
    run(7);
    chk("back_p0", 16'(page), 16'h0);
    run(3);
    freeze = 1'b1;
    run(20);
    chk("frz_page", 16'(page), 16'h0);
    chk("frz_dp", 16'(d8[0]), 16'h1);
    freeze = 1'b0;
    run(4);
    chk("frz_rel4", 16'(page), 16'h0);
    run(1);
    chk("frz_rel5", 16'(page), 16'h1);
    run(5);
    msg_code = 16'hE001; msg_req = 1'b1;
    cycle();
    msg_req = 1'b0;
    chk("msg_enter", 16'(msg_busy), 16'h1);
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("msg_blink", 16'(d1[5]), 16'(((i / 2) % 2) == 0));
      chk("msg_busy_hold", 16'(msg_busy), 16'(i < 11));
    end
    chk("msg_ret_page", 16'(page), 16'h1);
    run(2);
    chk("resume2", 16'(page), 16'h1);
    run(1);
    chk("resume3", 16'(page), 16'h0);
    run(7);
    msg_code = 16'hA5C3; msg_req = 1'b1;
    cycle();
    msg_req = 1'b0;
    chk("tc_msg", 16'(msg_busy), 16'h1);
    run(10);
    msg_code = 16'h0F0F; msg_req = 1'b1;
    cycle();
    msg_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("retrig_busy", 16'(msg_busy), 16'(i < 11));
    end
    chk("retrig_ret", 16'(page), 16'h0);
    cycle();
    chk("tc_saved", 16'(page), 16'h1);
    for (int i = 0; i < 400; i++) begin
      data_1 = 16'($urandom); data_2 = 16'($urandom); msg_code = 16'($urandom);
      gen_mod = 2'($urandom); prog = 3'($urandom);
      freeze = ($urandom % 4) == 0;
      msg_req = ($urandom % 12) == 0;
      cycle();
    end
    freeze = 1'b0;
    msg_code = 16'h7777; msg_req = 1'b1;
    cycle();
    msg_req = 1'b0;
    run(3);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("async_d%0d", k + 1), 16'(dig(k)), 16'h0);
    chk("async_busy", 16'(msg_busy), 16'h0);
    chk("async_page", 16'(page), 16'h0);
    model_reset();
    @(negedge clock) reset = 1'b1;
    cycle();
    chk("post_rst_page", 16'(page), 16'h0);
    run(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_page_sched.md
Name: dm_page_sched

Overview:
- Display page scheduler that time-shares the 8-digit seven-segment driver between several data sources.
- Rotates between two data pages on a timer.
- Overrides both pages with a blinking priority message for a fixed hold time.
- Sits between the datapath (data_1/data_2, gen_mod, prog) and dspl_drv_NexysA7; its d1..d8 outputs connect directly to the driver's digit inputs.

Parameters:
PAGE_TICKS, 100000000, clock cycles per data page (1 s at 100 MHz); must be >= 2
BLINK_TICKS, 25000000, clock cycles per blink half-period in message mode; must be >= 1
MSG_HOLD_TICKS, 200000000, clock cycles a message stays on screen; must be >= 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
data_1  in  16  page-1 value, shown as 4 hex digits
data_2  in  16  page-0 value, shown as 4 hex digits
gen_mod  in  2  generator mode, shown on page 0
prog  in  3  program number, shown on page 0
freeze  in  1  1 = hold the current data page; page timer paused
msg_req  in  1  one-cycle request to show msg_code
msg_code  in  16  message value, sampled when msg_req=1
msg_busy  out  1  1 while the message is displayed
page  out  2  0 = page 0, 1 = page 1, 2 = message; 3 never driven
d1..d8  out  6 each  digit fields {en, hex[3:0], dp}: bit5 enable, bits4:1 value, bit0 decimal point (1 = lit)

Behaviour:
- Reset (reset=0, asynchronous):
  - state = PAGE0, last_page = 0.
  - page_cnt, blink_cnt, hold_cnt all 0; blink_on = 1.
  - Outputs: d1..d8 = 6'b0 (blank), page = 0, msg_busy = 0.
- Output timing:
  - All outputs are registered.
  - d1..d8 reflect the state and inputs sampled at the previous rising edge: 1-cycle latency.
  - First non-blank frame appears at the first edge after reset deasserts.
- Digit contents by state:
  - PAGE0: d1..d4 = {1, data_2[4k+3:4k], 0} for k = 0..3 (d1 holds the LSB nibble). d5 = 0. d6 = {1, 2'b0, gen_mod, 0}. d7 = 0. d8 = {1, 1'b0, prog, 0}.
  - PAGE1: d1..d4 = data_1 nibbles in the same format. d5..d7 = 0. d8 = {1, 4'h1, 0}.
  - MSG: d1..d4 = {blink_on, msg_lat nibble, 0}. d5..d8 = 0.
  - In PAGE0 or PAGE1, d8 bit0 = freeze.
- FSM states: PAGE0, PAGE1, MSG.
- Page timer (PAGE0/PAGE1 only):
  - page_cnt increments each cycle while freeze = 0 and holds while freeze = 1.
  - At page_cnt = PAGE_TICKS-1 with freeze = 0: page_cnt goes to 0 and the state toggles PAGE0 <-> PAGE1.
- Message entry, from PAGE0/PAGE1 with msg_req = 1:
  - msg_lat <= msg_code; last_page <= current page.
  - hold_cnt <= 0, blink_cnt <= 0, blink_on <= 1; state <= MSG.
  - page_cnt keeps its value and stays paused for the whole MSG stay.
- MSG state:
  - hold_cnt increments each cycle.
  - blink_cnt counts 0..BLINK_TICKS-1; at terminal it goes to 0 and blink_on toggles.
  - At hold_cnt = MSG_HOLD_TICKS-1: return to last_page. page_cnt resumes from its saved value; blink_on <= 1.
- Retrigger:
  - msg_req = 1 while in MSG relatches msg_code and restarts hold_cnt, blink_cnt and blink_on.
  - Retrigger wins over hold expiry in the same cycle.
- Simultaneous events:
  - msg_req wins over a page-timer terminal count: no page toggle; page_cnt is not advanced or cleared.
  - freeze has no effect in MSG.
- Status outputs:
  - msg_busy = 1 exactly while the registered state is MSG.
  - page encodes the registered state.
- Reset asserted mid-message: immediate blank output; restart in PAGE0 with the message discarded.
- Counter widths: $clog2 of the respective TICKS parameter; no wrap occurs other than the terminal resets above.

Test Plan:
Bench parameters: PAGE_TICKS = 8, BLINK_TICKS = 2, MSG_HOLD_TICKS = 12.
- Reset, then release with data_2 = 16'hBEEF, gen_mod = 2, prog = 5 -> first edge: d1 = {1,F,0}, d4 = {1,B,0}, d6 = {1,4'h2,0}, d8 = {1,4'h5,0}, page = 0. Page 1 appears 8 cycles later.
- data_1 = 16'h1234, free-run 16 cycles -> page sequence 0 (8 cycles), 1 (8 cycles), 0. Page 1 shows d1 = {1,4,0} and d8 = {1,1,0}.
- freeze = 1 at page_cnt = 3 for 20 cycles -> page constant, d8 bit0 = 1. After release, toggle occurs exactly 5 cycles later.
- msg_req with msg_code = 16'hE001 at page_cnt = 5 in PAGE1:
  - msg_busy = 1 for 12 cycles; d1 en pattern is 1,1,0,0,...
  - Then page = 1, and toggle occurs 3 cycles after return.
- msg_req on the same cycle as the page terminal count -> MSG entered, last_page unchanged. Retrigger at hold_cnt = 10 -> msg_busy stays 1 for 12 more cycles.
- Assert reset during MSG -> d1..d8 = 0 and msg_busy = 0 asynchronously (before the next clock edge). After release, page = 0.
